// File: rtl/json_feedback_parser.sv
// Parses newline-terminated {"T":<uint>,"L":<num>,"R":<num>} frames from a UART byte stream.
// Fields update together with a 1-cycle frame_valid pulse one cycle after '\n'; malformed frames pulse parse_error.
module json_feedback_parser #(
  parameter int VAL_W   = 24,
  parameter int T_W     = 16,
  parameter int MAX_LEN = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             frame_valid,
  output logic [T_W-1:0]   t_val,
  output logic [VAL_W-1:0] l_val,
  output logic [VAL_W-1:0] r_val,
  output logic             parse_error
);

  localparam int ACC_W = VAL_W + 8;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [ACC_W-1:0] VMAX = ACC_W'((64'd1 << (VAL_W - 1)) - 64'd1);
  localparam logic [ACC_W-1:0] TMAX = ACC_W'((64'd1 << T_W) - 64'd1);

  localparam logic [7:0] CH_LBRACE = 8'h7B;
  localparam logic [7:0] CH_RBRACE = 8'h7D;
  localparam logic [7:0] CH_QUOTE  = 8'h22;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_NL     = 8'h0A;
  localparam logic [7:0] CH_SP     = 8'h20;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_T      = 8'h54;
  localparam logic [7:0] CH_L      = 8'h4C;
  localparam logic [7:0] CH_R      = 8'h52;

  typedef enum logic [3:0] {
    S_IDLE, S_Q_OPEN, S_KEY, S_Q_CLOSE, S_COLON,
    S_NUM_START, S_INT, S_FRAC, S_NL, S_ERR
  } state_t;

  typedef enum logic [1:0] {K_T, K_L, K_R} key_t;

  state_t             state;
  key_t               key;
  logic [ACC_W-1:0]   acc;
  logic [1:0]         nfrac;
  logic               neg;
  logic               got_digit;
  logic               seen_t, seen_l, seen_r;
  logic [LEN_W-1:0]   len;
  logic [T_W-1:0]     t_sh;
  logic [VAL_W-1:0]   l_sh, r_sh;

  logic               is_ws, is_dig, is_term;
  logic [3:0]         dig;
  logic [ACC_W-1:0]   acc_dig, dig_scaled, term_scaled, lim;
  logic [VAL_W-1:0]   term_val;
  logic [LEN_W-1:0]   len_nx;
  logic               byte_err;

  // dig_scaled is the value the field would have after this digit and final x100 scaling,
  // so overflow is caught at the digit that causes it rather than at the terminator.
  always_comb begin
    is_ws       = (rx_data == CH_SP) || (rx_data == CH_CR);
    is_dig      = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_term     = (rx_data == CH_COMMA) || (rx_data == CH_RBRACE);
    dig         = rx_data[3:0];
    acc_dig     = acc * ACC_W'(10) + ACC_W'(dig);
    lim         = (key == K_T) ? TMAX : VMAX;
    dig_scaled  = acc_dig;
    term_scaled = acc;
    if (key != K_T) begin
      if (state == S_INT)
        dig_scaled = acc_dig * ACC_W'(100);
      else if (nfrac == 2'd0)
        dig_scaled = acc_dig * ACC_W'(10);
      case (nfrac)
        2'd0:    term_scaled = acc * ACC_W'(100);
        2'd1:    term_scaled = acc * ACC_W'(10);
        default: term_scaled = acc;
      endcase
    end
    term_val = neg ? (VAL_W'(0) - term_scaled[VAL_W-1:0]) : term_scaled[VAL_W-1:0];
    len_nx   = len + LEN_W'(1);

    byte_err = 1'b0;
    case (state)
      S_Q_OPEN:    byte_err = !is_ws && (rx_data != CH_QUOTE);
      S_KEY:       byte_err = !is_ws && (rx_data != CH_T) && (rx_data != CH_L) && (rx_data != CH_R);
      S_Q_CLOSE:   byte_err = !is_ws && (rx_data != CH_QUOTE);
      S_COLON:     byte_err = !is_ws && (rx_data != CH_COLON);
      S_NUM_START: byte_err = !is_ws && !is_dig && !((rx_data == CH_MINUS) && (key != K_T));
      S_INT: begin
        if (is_dig)
          byte_err = dig_scaled > lim;
        else if (rx_data == CH_DOT)
          byte_err = (key == K_T) || !got_digit;
        else if (is_term)
          byte_err = !got_digit || (term_scaled > lim);
        else
          byte_err = 1'b1;
      end
      S_FRAC: begin
        if (is_dig)
          byte_err = (nfrac != 2'd2) && (dig_scaled > lim);
        else if (is_term)
          byte_err = term_scaled > lim;
        else
          byte_err = 1'b1;
      end
      S_NL: begin
        if (rx_data == CH_NL)
          byte_err = !(seen_t && seen_l && seen_r);
        else
          byte_err = !is_ws;
      end
      default: byte_err = 1'b0;
    endcase
    if ((len_nx == LEN_W'(MAX_LEN)) && (rx_data != CH_NL))
      byte_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      key         <= K_T;
      acc         <= '0;
      nfrac       <= '0;
      neg         <= 1'b0;
      got_digit   <= 1'b0;
      seen_t      <= 1'b0;
      seen_l      <= 1'b0;
      seen_r      <= 1'b0;
      len         <= '0;
      t_sh        <= '0;
      l_sh        <= '0;
      r_sh        <= '0;
      t_val       <= '0;
      l_val       <= '0;
      r_val       <= '0;
      frame_valid <= 1'b0;
      parse_error <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      parse_error <= 1'b0;
      if (rx_valid) begin
        case (state)
          S_IDLE: begin
            if (rx_data == CH_LBRACE) begin
              state  <= S_Q_OPEN;
              len    <= LEN_W'(1);
              seen_t <= 1'b0;
              seen_l <= 1'b0;
              seen_r <= 1'b0;
            end
          end
          // '{' is deliberately not a resync point: only '\n' ends a bad frame.
          S_ERR: begin
            if (rx_data == CH_NL)
              state <= S_IDLE;
          end
          default: begin
            len <= len_nx;
            if (byte_err) begin
              parse_error <= 1'b1;
              state       <= (rx_data == CH_NL) ? S_IDLE : S_ERR;
            end else if (!is_ws) begin
              case (state)
                S_Q_OPEN:  state <= S_KEY;
                S_KEY: begin
                  key   <= (rx_data == CH_T) ? K_T : (rx_data == CH_L) ? K_L : K_R;
                  state <= S_Q_CLOSE;
                end
                S_Q_CLOSE: state <= S_COLON;
                S_COLON: begin
                  acc       <= '0;
                  nfrac     <= '0;
                  neg       <= 1'b0;
                  got_digit <= 1'b0;
                  state     <= S_NUM_START;
                end
                S_NUM_START: begin
                  if (rx_data == CH_MINUS) begin
                    neg <= 1'b1;
                  end else begin
                    acc       <= ACC_W'(dig);
                    got_digit <= 1'b1;
                  end
                  state <= S_INT;
                end
                S_INT, S_FRAC: begin
                  if (is_dig) begin
                    if (state == S_INT) begin
                      acc       <= acc_dig;
                      got_digit <= 1'b1;
                    end else if (nfrac != 2'd2) begin
                      acc   <= acc_dig;
                      nfrac <= nfrac + 2'd1;
                    end
                  end else if (rx_data == CH_DOT) begin
                    state <= S_FRAC;
                  end else begin
                    case (key)
                      K_T: begin
                        t_sh   <= acc[T_W-1:0];
                        seen_t <= 1'b1;
                      end
                      K_L: begin
                        l_sh   <= term_val;
                        seen_l <= 1'b1;
                      end
                      default: begin
                        r_sh   <= term_val;
                        seen_r <= 1'b1;
                      end
                    endcase
                    state <= (rx_data == CH_COMMA) ? S_Q_OPEN : S_NL;
                  end
                end
                S_NL: begin
                  t_val       <= t_sh;
                  l_val       <= l_sh;
                  r_val       <= r_sh;
                  frame_valid <= 1'b1;
                  state       <= S_IDLE;
                end
                default: state <= S_IDLE;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_json_feedback_parser.sv
// Directed bench for json_feedback_parser: hand-decoded frames, error cases and reset behaviour.
module tb_json_feedback_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_valid;
  logic        parse_error;
  logic [15:0] t_val;
  logic [23:0] l_val;
  logic [23:0] r_val;

  int n_pass = 0;
  int n_total = 0;
  int fv_cnt = 0;
  int pe_cnt = 0;
  int both_cnt = 0;
  int fv0 = 0;
  int pe0 = 0;

  always #5 clk = ~clk;

  json_feedback_parser #(.VAL_W(24), .T_W(16), .MAX_LEN(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_valid (frame_valid),
    .t_val       (t_val),
    .l_val       (l_val),
    .r_val       (r_val),
    .parse_error (parse_error)
  );

  always @(posedge clk) begin
    #1;
    if (frame_valid) fv_cnt++;
    if (parse_error) pe_cnt++;
    if (frame_valid && parse_error) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
  endtask

  task automatic mark();
    fv0 = fv_cnt;
    pe0 = pe_cnt;
  endtask

  task automatic expect_frame(input string tag, input int dfv, input int dpe,
                              input logic [31:0] t, input logic [31:0] l, input logic [31:0] r);
    repeat (3) @(negedge clk);
    check({tag, "_fv"}, 32'(fv_cnt - fv0), 32'(dfv));
    check({tag, "_pe"}, 32'(pe_cnt - pe0), 32'(dpe));
    check({tag, "_t"}, {16'h0, t_val}, t);
    check({tag, "_l"}, {8'h0, l_val}, l);
    check({tag, "_r"}, {8'h0, r_val}, r);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_fv", {31'h0, frame_valid}, 32'h0);
    check("rst_pe", {31'h0, parse_error}, 32'h0);
    check("rst_t", {16'h0, t_val}, 32'h0);
    check("rst_l", {8'h0, l_val}, 32'h0);
    check("rst_r", {8'h0, r_val}, 32'h0);

    // basic frame, one byte every 10 clocks
    mark();
    send_str("{\"T\":11,\"L\":164,\"R\":164}\n", 9);
    expect_frame("t1", 1, 0, 32'd11, 32'd16400, 32'd16400);

    // fractions and negative values
    mark();
    send_str("{\"T\":1,\"L\":0.5,\"R\":-0.25}\n", 1);
    expect_frame("t2a", 1, 0, 32'd1, 32'd50, 32'h00FFFFE7);
    mark();
    send_str("{\"T\":1,\"L\":1.999,\"R\":-0.25}\n", 0);
    expect_frame("t2b", 1, 0, 32'd1, 32'd199, 32'h00FFFFE7);

    // unknown key leaves outputs alone, next good frame (with whitespace) decodes
    mark();
    send_str("{\"T\":11,\"L\":164,\"R\":164}\n", 0);
    expect_frame("t3a", 1, 0, 32'd11, 32'd16400, 32'd16400);
    mark();
    send_str("{\"T\":1,\"X\":2}\n", 0);
    expect_frame("t3b", 0, 1, 32'd11, 32'd16400, 32'd16400);
    mark();
    send_str("{ \"T\" : 7,\"L\" :-3,\"R\": 12.3}\r\n", 0);
    expect_frame("t3c", 1, 0, 32'd7, 32'h00FFFED4, 32'd1230);

    // overflow limits
    mark();
    send_str("{\"T\":1,\"L\":99999,\"R\":0}\n", 0);
    expect_frame("t4a", 0, 1, 32'd7, 32'h00FFFED4, 32'd1230);
    mark();
    send_str("{\"T\":70000,\"L\":1,\"R\":1}\n", 0);
    expect_frame("t4b", 0, 1, 32'd7, 32'h00FFFED4, 32'd1230);
    mark();
    send_str("{\"T\":1,\"L\":83886.08,\"R\":0}\n", 0);
    expect_frame("t4c", 0, 1, 32'd7, 32'h00FFFED4, 32'd1230);
    mark();
    send_str("{\"T\":65535,\"L\":83886.07,\"R\":-83886.07}\n", 0);
    expect_frame("t4d", 1, 0, 32'd65535, 32'h007FFFFF, 32'h00800001);

    // missing field
    mark();
    send_str("{\"T\":1,\"L\":2}\n", 0);
    expect_frame("t5a", 0, 1, 32'd65535, 32'h007FFFFF, 32'h00800001);

    // over-length frame: error exactly on byte 64, reported once
    mark();
    send_byte(8'h7B, 0);
    for (int i = 0; i < 62; i++) send_byte(8'h20, 0);
    repeat (3) @(negedge clk);
    check("len63_pe", 32'(pe_cnt - pe0), 32'd0);
    send_byte(8'h20, 0);
    repeat (3) @(negedge clk);
    check("len64_pe", 32'(pe_cnt - pe0), 32'd1);
    for (int i = 0; i < 6; i++) send_byte(8'h20, 0);
    send_byte(8'h0A, 0);
    expect_frame("t5b", 0, 1, 32'd65535, 32'h007FFFFF, 32'h00800001);

    // '{' while discarding does not restart a frame
    mark();
    send_str("{\"T\":1,\"X\"{\"T\":2,\"L\":2,\"R\":2}\n", 0);
    expect_frame("t5c", 0, 1, 32'd65535, 32'h007FFFFF, 32'h00800001);

    // reset mid-frame
    mark();
    send_str("{\"T\":1,\"L\":", 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_frame("t6a", 0, 0, 32'd0, 32'd0, 32'd0);

    // back-to-back frames at full rate
    mark();
    send_str("{\"T\":3,\"L\":4,\"R\":5}\n{\"T\":6,\"L\":-7,\"R\":8}\n", 0);
    expect_frame("t6b", 2, 0, 32'd6, 32'h00FFFD44, 32'd800);

    check("no_coincident_pulses", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
